matrix_gen_3x3_param: RTL and testbench
=======================================

# matrix_gen_3x3_param

Parametrised 3x3 neighbourhood generator for the streaming video pipeline. It sits between the CMOS/greyscale front end and window operators such as Sobel, median and erosion/dilation. It takes one pixel per `per_frame_clken` in raster order, buffers two full lines internally, and emits a 3x3 window per accepted pixel with aligned sync, centre coordinates and a window-valid flag. It generalises data width, adds frame tracking, overrun protection and optional zero padding.

## Interface
- `DATA_W`, 8: pixel width in bits (1..16).
- `IMG_HDISP`, 640: active pixels per line (3..2047).
- `IMG_VDISP`, 480: active lines per frame (3..2047).
- `clk` in 1: pixel clock.
- `rst_n` in 1: reset, asynchronous, active-low. Clock is `clk`.
- `per_frame_vsync` in 1: frame sync, high during active frame.
- `per_frame_href` in 1: line valid.
- `per_frame_clken` in 1: pixel strobe; valid only while `per_frame_href`=1.
- `per_img_data` in DATA_W: pixel.
- `matrix_frame_vsync`, `matrix_frame_href`, `matrix_frame_clken` out 1: inputs delayed 2 cycles. `clken` is additionally gated by pixel acceptance.
- `matrix_p11..matrix_p33` out DATA_W each: window. Row 1 is the oldest line; column 3 is the newest pixel.
- `matrix_x`, `matrix_y` out 11: coordinates of the window centre (p22).
- `matrix_valid` out 1: all nine taps are real image pixels.
- `line_err` out 1: sticky overrun flag. Cleared at the vsync rising edge.

## Operation
- FSM states:
  - WAIT_FRAME: the reset state. Moves to ACTIVE on a `per_frame_vsync` rising edge.
  - ACTIVE: on a vsync falling edge, moves back to WAIT_FRAME.
  - In WAIT_FRAME all input pixels are ignored.
- Counters, both cleared on the vsync rising edge:
  - Column counter `x`: +1 per accepted pixel; cleared on the href falling edge.
  - Row counter `y`: +1 on the href falling edge if the line had at least one accepted pixel.
- Accepted pixel: state ACTIVE, href=1, clken=1, `x` < IMG_HDISP and `y` < IMG_VDISP.
  - A pixel with `x` ≥ IMG_HDISP or `y` ≥ IMG_VDISP is dropped: no buffer write, no output clken, and `line_err` is set.
- Line buffers: two RAMs, IMG_HDISP × DATA_W, addressed by `x`.
  - Per accepted pixel at column `x`: read `lb0[x]` (row y-1) and `lb1[x]` (row y-2); write `lb1[x]`←`lb0[x]` and `lb0[x]`←pixel.
  - Contents are not reset.
- Window: three shift registers of 3 taps each, shifted left on each delayed accepted strobe.
  - New column = {lb1 read, lb0 read, registered pixel} → {p13, p23, p33}.
- When `matrix_frame_href` is low, all window taps are forced to 0 (line-start clear).
- Output fields for the window of input pixel (x,y):
  - `matrix_x` = x-1, `matrix_y` = y-1 (both wrap modulo 2^11 when x or y is 0).
  - `matrix_valid` = (x ≥ 2 && y ≥ 2).
- The last column and last row of centres are never emitted. Consumers treat `matrix_valid`=0 windows as border.

## Timing
- Latency is 2 clk from an accepted `per_frame_clken` to `matrix_frame_clken`.
  - Stage 1: input register and RAM read.
  - Stage 2: window shift.
- Window outputs, `matrix_x/y` and `matrix_valid` update only in the `matrix_frame_clken` cycle and hold otherwise.
- Back-to-back clken on every cycle is supported. Gaps of any length are supported.
- Simultaneous href fall and vsync fall: the row increments, then the FSM enters WAIT_FRAME.
- A vsync rising edge in the same cycle as an accepted pixel: counters clear first, and the pixel is taken as (0,0).
- Reset values: all outputs are 0, FSM is WAIT_FRAME, counters are 0. Asserting reset mid-frame drops the remainder of that frame until the next vsync rising edge.

## Configuration
- `MATRIX_ZERO_PAD_EN` defined: taps outside the image read exactly 0.
  - Rows y-2 or y-1 < 0 are masked at the RAM output.
  - Columns are naturally 0 through the line-start clear.
  - Non-valid windows are therefore deterministic.
- Undefined: row taps with y < 2 carry stale line-buffer contents. Only `matrix_valid`=1 windows are defined.

## Test plan
Common setup: DATA_W=8, IMG_HDISP=8, IMG_VDISP=6, pixel value = 16·y + x, continuous clken, 4-cycle href gaps.

- Full frame, pixel (4,3) input at cycle T:
  - Required at T+2: clken=1, p11=0x12, p22=0x23, p33=0x34, x=3, y=2, valid=1.
- Pixel (1,3):
  - Required: valid=0, p11=0 (line-start clear), p13=0x11, p33=0x31.
- `MATRIX_ZERO_PAD_EN` defined, pixel (3,1):
  - Required: p11, p12, p13 = 0, p33=0x13, valid=0.
- Line with 10 clken pulses:
  - Required: exactly 8 output clken, `line_err`=1.
  - The next line's window contents are unaffected.
  - `line_err`=0 after the next vsync rising edge.
- Reset pulse in mid-row 2, then pixels with vsync held high:
  - Required: no output clken until the vsync falls and rises again.
  - The new frame starts with `matrix_y` wrap value 2047 at y=0 and valid=0.

Source files
------------

// File: rtl/matrix_gen_3x3_param.sv
// -----------------------------------------------------------------------------
// matrix_gen_3x3_param
//
// Streaming 3x3 neighbourhood generator. Takes one pixel per per_frame_clken in
// raster order, keeps two full lines in internal RAMs and produces one 3x3
// window per accepted pixel, two clocks later. It also outputs the centre
// coordinates, a window-valid flag and a sticky overrun flag.
//
// Optional feature macro: MATRIX_ZERO_PAD_EN
//   defined   : rows above the image (y-1 < 0, y-2 < 0) read as 0, so every
//               window is deterministic.
//   undefined : those rows carry stale line-buffer contents. Only windows with
//               matrix_valid=1 are defined.
//
// Ports
//   clk, rst_n                    pixel clock, asynchronous active-low reset
//   per_frame_vsync/href/clken    input sync; clken is a pixel strobe that only
//                                 counts while href=1
//   per_img_data [DATA_W]         input pixel
//   matrix_frame_vsync/href/clken sync delayed by 2 clocks. clken only fires
//                                 for accepted pixels.
//   matrix_p11..p33 [DATA_W]      window; row 1 is the oldest line, column 3 is
//                                 the newest pixel
//   matrix_x, matrix_y [11]       window centre coordinates (wrap at 0)
//   matrix_valid                  all nine taps are real image pixels
//   line_err                      sticky overrun flag, cleared at vsync rise
//   dbg_state                     FSM state (0 = WAIT_FRAME, 1 = ACTIVE)
//
// Handshake: there is no back-pressure. A pixel is transferred on every clk
// edge where per_frame_href=1 and per_frame_clken=1. The output window is
// valid on every clk edge where matrix_frame_clken=1, and it holds otherwise.
// -----------------------------------------------------------------------------
module matrix_gen_3x3_param #(
   parameter int DATA_W    = 8,
   parameter int IMG_HDISP = 640,
   parameter int IMG_VDISP = 480
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              per_frame_vsync,
   input  logic              per_frame_href,
   input  logic              per_frame_clken,
   input  logic [DATA_W-1:0] per_img_data,
   output logic              matrix_frame_vsync,
   output logic              matrix_frame_href,
   output logic              matrix_frame_clken,
   output logic [DATA_W-1:0] matrix_p11,
   output logic [DATA_W-1:0] matrix_p12,
   output logic [DATA_W-1:0] matrix_p13,
   output logic [DATA_W-1:0] matrix_p21,
   output logic [DATA_W-1:0] matrix_p22,
   output logic [DATA_W-1:0] matrix_p23,
   output logic [DATA_W-1:0] matrix_p31,
   output logic [DATA_W-1:0] matrix_p32,
   output logic [DATA_W-1:0] matrix_p33,
   output logic [10:0]       matrix_x,
   output logic [10:0]       matrix_y,
   output logic              matrix_valid,
   output logic              line_err,
   output logic              dbg_state
);

   localparam int AW = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;

   typedef enum logic {WAIT_FRAME = 1'b0, ACTIVE = 1'b1} state_t;
   state_t state, state_nxt;

   // Edge detectors. vsync_q resets to 1 so that a vsync held high through a
   // mid-frame reset is not seen as a new frame start.
   logic vsync_q, href_q;
   logic vs_rise, vs_fall, href_fall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vsync_q <= 1'b1;
         href_q  <= 1'b0;
      end else begin
         vsync_q <= per_frame_vsync;
         href_q  <= per_frame_href;
      end
   end

   assign vs_rise   = per_frame_vsync & ~vsync_q;
   assign vs_fall   = ~per_frame_vsync & vsync_q;
   assign href_fall = ~per_frame_href & href_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= WAIT_FRAME;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         WAIT_FRAME: if (vs_rise) state_nxt = ACTIVE;
         ACTIVE:     if (vs_fall) state_nxt = WAIT_FRAME;
         default:    state_nxt = WAIT_FRAME;
      endcase
   end

   assign dbg_state = state;

   // Counters. A vsync rise clears them in the same cycle, so a pixel that
   // arrives together with the rising edge is taken as (0,0).
   logic [10:0] x_cnt, y_cnt, x_eff, y_eff;
   logic        line_had;
   logic        pix_in, in_range, accept, drop;

   assign x_eff    = vs_rise ? 11'd0 : x_cnt;
   assign y_eff    = vs_rise ? 11'd0 : y_cnt;
   assign pix_in   = ((state == ACTIVE) | vs_rise) & per_frame_href & per_frame_clken;
   assign in_range = (x_eff < 11'(IMG_HDISP)) && (y_eff < 11'(IMG_VDISP));
   assign accept   = pix_in & in_range;
   assign drop     = pix_in & ~in_range;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_cnt    <= '0;
         y_cnt    <= '0;
         line_had <= 1'b0;
         line_err <= 1'b0;
      end else begin
         if (vs_rise) begin
            x_cnt    <= accept ? 11'd1 : 11'd0;
            y_cnt    <= '0;
            line_had <= accept;
         end else if (href_fall) begin
            x_cnt    <= '0;
            line_had <= 1'b0;
            if (line_had) y_cnt <= y_cnt + 11'd1;
         end else if (accept) begin
            x_cnt    <= x_cnt + 11'd1;
            line_had <= 1'b1;
         end
         // Clear happens first so that an overrun in the same cycle still sets it.
         line_err <= (vs_rise ? 1'b0 : line_err) | drop;
      end
   end

   // Line buffers: lb0 holds row y-1, lb1 holds row y-2. Read-before-write, so
   // each accepted pixel pushes the column down by one row.
   logic [DATA_W-1:0] lb0 [0:IMG_HDISP-1];
   logic [DATA_W-1:0] lb1 [0:IMG_HDISP-1];
   logic [DATA_W-1:0] lb0_rd, lb1_rd;
   logic [AW-1:0]     addr;

   assign addr = x_eff[AW-1:0];

   always_ff @(posedge clk) begin
      if (accept) begin
         lb0[addr] <= per_img_data;
         lb1[addr] <= lb0[addr];
         lb0_rd    <= lb0[addr];
         lb1_rd    <= lb1[addr];
      end
   end

   // Stage 1 register
   logic [DATA_W-1:0] pix_q;
   logic [10:0]       x_d1, y_d1;
   logic              acc_d1, vs_d1, href_d1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_q   <= '0;
         x_d1    <= '0;
         y_d1    <= '0;
         acc_d1  <= 1'b0;
         vs_d1   <= 1'b0;
         href_d1 <= 1'b0;
      end else begin
         acc_d1  <= accept;
         vs_d1   <= per_frame_vsync;
         href_d1 <= per_frame_href;
         if (accept) begin
            pix_q <= per_img_data;
            x_d1  <= x_eff;
            y_d1  <= y_eff;
         end
      end
   end

   logic [DATA_W-1:0] col_top, col_mid;

`ifdef MATRIX_ZERO_PAD_EN
   // Row-existence flags travel with the RAM read data.
   logic row1_ok, row2_ok;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row1_ok <= 1'b0;
         row2_ok <= 1'b0;
      end else if (accept) begin
         row1_ok <= (y_eff >= 11'd1);
         row2_ok <= (y_eff >= 11'd2);
      end
   end

   assign col_top = row2_ok ? lb1_rd : '0;
   assign col_mid = row1_ok ? lb0_rd : '0;
`else
   assign col_top = lb1_rd;
   assign col_mid = lb0_rd;
`endif

   // Stage 2: window shift. Taps are cleared whenever href is low at this stage.
   // As a result, the first columns of each line read 0 instead of the previous
   // line's tail.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         matrix_frame_vsync <= 1'b0;
         matrix_frame_href  <= 1'b0;
         matrix_frame_clken <= 1'b0;
         matrix_p11 <= '0; matrix_p12 <= '0; matrix_p13 <= '0;
         matrix_p21 <= '0; matrix_p22 <= '0; matrix_p23 <= '0;
         matrix_p31 <= '0; matrix_p32 <= '0; matrix_p33 <= '0;
         matrix_x     <= '0;
         matrix_y     <= '0;
         matrix_valid <= 1'b0;
      end else begin
         matrix_frame_vsync <= vs_d1;
         matrix_frame_href  <= href_d1;
         matrix_frame_clken <= acc_d1;
         if (!href_d1) begin
            matrix_p11 <= '0; matrix_p12 <= '0; matrix_p13 <= '0;
            matrix_p21 <= '0; matrix_p22 <= '0; matrix_p23 <= '0;
            matrix_p31 <= '0; matrix_p32 <= '0; matrix_p33 <= '0;
         end else if (acc_d1) begin
            matrix_p11 <= matrix_p12; matrix_p12 <= matrix_p13; matrix_p13 <= col_top;
            matrix_p21 <= matrix_p22; matrix_p22 <= matrix_p23; matrix_p23 <= col_mid;
            matrix_p31 <= matrix_p32; matrix_p32 <= matrix_p33; matrix_p33 <= pix_q;
         end
         if (acc_d1) begin
            matrix_x     <= x_d1 - 11'd1;
            matrix_y     <= y_d1 - 11'd1;
            matrix_valid <= (x_d1 >= 11'd2) && (y_d1 >= 11'd2);
         end
      end
   end

endmodule

// File: tb/tb_matrix_gen_3x3_param.sv
// -----------------------------------------------------------------------------
// Testbench for matrix_gen_3x3_param, configured as an 8x6 image with
// pixel = 16*y + x. It sends full frames, an overrun line, a mid-frame reset
// and a frame whose first pixel arrives together with the vsync rise. Every
// output window is captured into a queue in arrival order, so window k
// belongs to input pixel k of the frame.
// -----------------------------------------------------------------------------
module tb_matrix_gen_3x3_param;

   localparam int DW = 8;
   localparam int HD = 8;
   localparam int VD = 6;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          per_frame_vsync = 1'b0;
   logic          per_frame_href  = 1'b0;
   logic          per_frame_clken = 1'b0;
   logic [DW-1:0] per_img_data    = '0;
   logic          matrix_frame_vsync, matrix_frame_href, matrix_frame_clken;
   logic [DW-1:0] matrix_p11, matrix_p12, matrix_p13;
   logic [DW-1:0] matrix_p21, matrix_p22, matrix_p23;
   logic [DW-1:0] matrix_p31, matrix_p32, matrix_p33;
   logic [10:0]   matrix_x, matrix_y;
   logic          matrix_valid, line_err, dbg_state;

   matrix_gen_3x3_param #(.DATA_W(DW), .IMG_HDISP(HD), .IMG_VDISP(VD)) dut (
      .clk(clk), .rst_n(rst_n),
      .per_frame_vsync(per_frame_vsync), .per_frame_href(per_frame_href),
      .per_frame_clken(per_frame_clken), .per_img_data(per_img_data),
      .matrix_frame_vsync(matrix_frame_vsync), .matrix_frame_href(matrix_frame_href),
      .matrix_frame_clken(matrix_frame_clken),
      .matrix_p11(matrix_p11), .matrix_p12(matrix_p12), .matrix_p13(matrix_p13),
      .matrix_p21(matrix_p21), .matrix_p22(matrix_p22), .matrix_p23(matrix_p23),
      .matrix_p31(matrix_p31), .matrix_p32(matrix_p32), .matrix_p33(matrix_p33),
      .matrix_x(matrix_x), .matrix_y(matrix_y), .matrix_valid(matrix_valid),
      .line_err(line_err), .dbg_state(dbg_state)
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // capture of emitted windows
   typedef struct {
      logic [DW-1:0] p11, p12, p13, p21, p22, p23, p31, p32, p33;
      logic [10:0]   mx, my;
      logic          v;
      int            cyc;
   } win_t;
   win_t out_q[$];

   always @(negedge clk) begin
      if (rst_n && matrix_frame_clken) begin
         win_t w;
         w.p11 = matrix_p11; w.p12 = matrix_p12; w.p13 = matrix_p13;
         w.p21 = matrix_p21; w.p22 = matrix_p22; w.p23 = matrix_p23;
         w.p31 = matrix_p31; w.p32 = matrix_p32; w.p33 = matrix_p33;
         w.mx = matrix_x; w.my = matrix_y; w.v = matrix_valid; w.cyc = cyc;
         out_q.push_back(w);
      end
   end

   function automatic win_t get_win(input int idx);
      win_t w;
      w = '{default: '0};
      if (idx < out_q.size()) w = out_q[idx];
      return w;
   endfunction

   // scoreboard counters and comparison
   int checks = 0;
   int errors = 0;
   int t43 = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_line(input int y, input int npix);
      for (int x = 0; x < npix; x++) begin
         per_frame_href  = 1'b1;
         per_frame_clken = 1'b1;
         per_img_data    = 8'((16 * y + x) & 8'hff);
         if (x == 4 && y == 3) t43 = cyc;
         tick();
      end
      per_frame_href  = 1'b0;
      per_frame_clken = 1'b0;
      repeat (4) tick();
   endtask

   task automatic end_frame();
      per_frame_vsync = 1'b0;
      repeat (4) tick();
   endtask

   win_t w;
   int   n0;

   initial begin
      // reset
      repeat (3) tick();
      check("rst_clken", matrix_frame_clken, 0);
      check("rst_p22", matrix_p22, 0);
      check("rst_x", matrix_x, 0);
      check("rst_valid", matrix_valid, 0);
      check("rst_line_err", line_err, 0);
      check("rst_state", dbg_state, 0);
      rst_n = 1'b1;
      repeat (2) tick();

      // frame 1: full frame
      per_frame_vsync = 1'b1;
      repeat (2) tick();
      check("f1_state_active", dbg_state, 1);
      for (int y = 0; y < VD; y++) send_line(y, HD);
      end_frame();
      check("f1_count", out_q.size(), 48);
      check("f1_state_wait", dbg_state, 0);
      w = get_win(28);
      check("f1_43_latency", w.cyc - t43, 2);
      check("f1_43_p11", w.p11, 8'h12);
      check("f1_43_p13", w.p13, 8'h14);
      check("f1_43_p22", w.p22, 8'h23);
      check("f1_43_p33", w.p33, 8'h34);
      check("f1_43_x", w.mx, 3);
      check("f1_43_y", w.my, 2);
      check("f1_43_valid", w.v, 1);
      w = get_win(25);
      check("f1_13_valid", w.v, 0);
      check("f1_13_p11", w.p11, 8'h00);
      check("f1_13_p31", w.p31, 8'h00);
      check("f1_13_p13", w.p13, 8'h11);
      check("f1_13_p33", w.p33, 8'h31);
      w = get_win(0);
      check("f1_00_x", w.mx, 2047);
      check("f1_00_y", w.my, 2047);
      check("f1_00_valid", w.v, 0);
      w = get_win(47);
      check("f1_75_p11", w.p11, 8'h35);
      check("f1_75_p33", w.p33, 8'h57);
      check("f1_75_valid", w.v, 1);
`ifdef MATRIX_ZERO_PAD_EN
      w = get_win(11);
      check("zp_31_p11", w.p11, 8'h00);
      check("zp_31_p12", w.p12, 8'h00);
      check("zp_31_p13", w.p13, 8'h00);
      check("zp_31_p33", w.p33, 8'h13);
      check("zp_31_valid", w.v, 0);
`endif
      check("f1_line_err", line_err, 0);

      // frame 2: line 2 has 10 strobes, the last two overrun
      out_q.delete();
      per_frame_vsync = 1'b1;
      repeat (2) tick();
      send_line(0, HD);
      send_line(1, HD);
      n0 = out_q.size();
      send_line(2, 10);
      check("f2_overrun_count", out_q.size() - n0, 8);
      check("f2_line_err_set", line_err, 1);
      for (int y = 3; y < VD; y++) send_line(y, HD);
      end_frame();
      check("f2_count", out_q.size(), 48);
      w = get_win(28);
      check("f2_43_p11", w.p11, 8'h12);
      check("f2_43_p13", w.p13, 8'h14);
      check("f2_43_p22", w.p22, 8'h23);
      check("f2_43_p33", w.p33, 8'h34);
      check("f2_line_err_sticky", line_err, 1);

      // frame 3: flag clears on vsync rise, then a reset in the middle of row 2
      out_q.delete();
      per_frame_vsync = 1'b1;
      repeat (2) tick();
      check("f3_line_err_clr", line_err, 0);
      send_line(0, HD);
      send_line(1, HD);
      for (int x = 0; x < 4; x++) begin
         per_frame_href  = 1'b1;
         per_frame_clken = 1'b1;
         per_img_data    = 8'(32 + x);
         tick();
      end
      rst_n = 1'b0;
      #1;
      check("mrst_clken", matrix_frame_clken, 0);
      check("mrst_p33", matrix_p33, 0);
      check("mrst_state", dbg_state, 0);
      tick();
      rst_n = 1'b1;
      n0 = out_q.size();
      for (int x = 4; x < HD; x++) begin
         per_img_data = 8'(32 + x);
         tick();
      end
      per_frame_href  = 1'b0;
      per_frame_clken = 1'b0;
      repeat (4) tick();
      for (int y = 3; y < VD; y++) send_line(y, HD);
      check("mrst_no_out", out_q.size() - n0, 0);
      check("mrst_state_held", dbg_state, 0);
      end_frame();
      check("mrst_no_out_end", out_q.size() - n0, 0);

      // frame 4: the vsync rise and the first pixel arrive in the same cycle
      out_q.delete();
      per_frame_vsync = 1'b1;
      for (int y = 0; y < VD; y++) send_line(y, HD);
      end_frame();
      check("f4_count", out_q.size(), 48);
      w = get_win(0);
      check("f4_00_y", w.my, 2047);
      check("f4_00_x", w.mx, 2047);
      check("f4_00_valid", w.v, 0);
      w = get_win(1);
      check("f4_10_p33", w.p33, 8'h01);
      check("f4_10_x", w.mx, 0);
      w = get_win(28);
      check("f4_43_latency", w.cyc - t43, 2);
      check("f4_43_p11", w.p11, 8'h12);
      check("f4_43_p22", w.p22, 8'h23);
      check("f4_43_p33", w.p33, 8'h34);
      check("f4_43_valid", w.v, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
